piso_shift_tx: RTL and testbench

- Parallel-in serial-out transmitter: the sending end of the team's serial shift-register link.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk on sout, with framing strobes.
- An optional idle gap follows each frame.
- Feeds the serial-in shift-register chain built from the team's asynchronous-reset D flip-flops.

---
 rtl/piso_shift_tx.sv | 119 +++++++++++
 tb/tb_piso_shift_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter for the serial shift-register link.
// A word accepted over valid/ready is shifted out one bit per clock on sout.
// sout_valid, frame_start and frame_done frame the word, and an optional idle
// gap follows each frame. All serial-side outputs come straight from flops so
// the downstream shift chain sees clean, glitch-free levels.
module piso_shift_tx #(
    parameter int WIDTH      = 6,
    parameter int LSB_FIRST  = 0,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_PENULT = BW'(WIDTH - 2);
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    // Bit that sits at the output end of the register for the chosen bit order.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
    endfunction

    // Move the register one place toward the output end, filling with zero.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
    endfunction

    // Frame FSM: outputs for the next cycle are computed alongside the state,
    // so the current sout always equals the output-end bit of shreg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state       <= SHIFT;
                        shreg       <= load_data;
                        bit_cnt     <= '0;
                        sout        <= out_bit(load_data);
                        sout_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        frame_done  <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg <= shift_toward_out(shreg);
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt     <= '0;
                        sout        <= 1'b0;
                        sout_valid  <= 1'b0;
                        frame_start <= 1'b0;
                        frame_done  <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt     <= bit_cnt + 1'b1;
                        sout        <= out_bit(shift_toward_out(shreg));
                        frame_start <= 1'b0;
                        frame_done  <= (bit_cnt == BIT_PENULT);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = (state == IDLE);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three instances (MSB-first/gap 1, LSB-first/gap 1,
// MSB-first/gap 0) share clock and reset. A per-instance queue holds the
// expected output record for every cycle of a frame plus its gap; an empty
// queue means the instance should be idle and ready.
module tb_piso_shift_tx;

    localparam int W = 6;

    // Output record packing: {sout, sout_valid, frame_start, frame_done, busy, load_ready}
    localparam logic [5:0] IDLE_REC = 6'b000001;
    localparam logic [5:0] GAP_REC  = 6'b000010;

    typedef struct {
        logic         r;
        logic         lv;
        logic [W-1:0] d;
        logic [5:0]   exp;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [2:0]   lv;
    logic [W-1:0] ld [3];
    logic [2:0]   sout_w, sv_w, fs_w, fd_w, busy_w, rdy_w;

    logic [5:0]   q [3][$];
    int           checks;
    int           errors;

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(0), .GAP_CYCLES(1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(rdy_w[0]),
        .load_data(ld[0]), .sout(sout_w[0]), .sout_valid(sv_w[0]),
        .frame_start(fs_w[0]), .frame_done(fd_w[0]), .busy(busy_w[0])
    );

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1), .GAP_CYCLES(1)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(rdy_w[1]),
        .load_data(ld[1]), .sout(sout_w[1]), .sout_valid(sv_w[1]),
        .frame_start(fs_w[1]), .frame_done(fd_w[1]), .busy(busy_w[1])
    );

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(0), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(rdy_w[2]),
        .load_data(ld[2]), .sout(sout_w[2]), .sout_valid(sv_w[2]),
        .frame_start(fs_w[2]), .frame_done(fd_w[2]), .busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b required %b (sout,vld,start,done,busy,ready)",
                     name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] sample(input int i);
        return {sout_w[i], sv_w[i], fs_w[i], fd_w[i], busy_w[i], rdy_w[i]};
    endfunction

    // Queue the expected per-cycle records for one accepted word.
    task automatic push_frame(input int i, input logic [W-1:0] d);
        logic b;
        int   gap;
        gap = (i == 2) ? 0 : 1;
        for (int k = 0; k < W; k++) begin
            b = (i == 1) ? d[k] : d[W-1-k];
            q[i].push_back({b, 1'b1, (k == 0), (k == W-1), 1'b1, 1'b0});
        end
        for (int g = 0; g < gap; g++) q[i].push_back(GAP_REC);
    endtask

    // One clock cycle: drive inputs at the falling edge, check this cycle's
    // outputs, then predict whether the next rising edge accepts a word.
    task automatic step(input logic r, input logic [2:0] v,
                        input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic use_tab, input logic [5:0] tab);
        logic [W-1:0] dd [3];
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        @(negedge clk);
        reset = r;
        lv    = v;
        ld[0] = d0; ld[1] = d1; ld[2] = d2;
        #1;
        if (use_tab) chk("table", sample(0), tab);
        for (int i = 0; i < 3; i++) begin
            if (r) q[i].delete();
            if (q[i].size() > 0) begin
                chk($sformatf("sb%0d", i), sample(i), q[i].pop_front());
            end else begin
                chk($sformatf("sb%0d_idle", i), sample(i), IDLE_REC);
                if (!r && v[i]) push_frame(i, dd[i]);
            end
        end
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'b000, '0, '0, '0, 1'b0, '0);
    endtask

    vec_t tab [12];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        lv     = 3'b000;
        ld[0]  = '0; ld[1] = '0; ld[2] = '0;

        // Reset with load_valid held, release, accept 110010 MSB-first; load_valid
        // stays high with junk data during SHIFT and GAP and must be ignored.
        tab[0]  = '{1'b1, 1'b1, 6'b110010, 6'b000001};
        tab[1]  = '{1'b1, 1'b1, 6'b110010, 6'b000001};
        tab[2]  = '{1'b0, 1'b1, 6'b110010, 6'b000001};
        tab[3]  = '{1'b0, 1'b1, 6'b000111, 6'b111010};
        tab[4]  = '{1'b0, 1'b1, 6'b000111, 6'b110010};
        tab[5]  = '{1'b0, 1'b1, 6'b000111, 6'b010010};
        tab[6]  = '{1'b0, 1'b1, 6'b000111, 6'b010010};
        tab[7]  = '{1'b0, 1'b1, 6'b000111, 6'b110010};
        tab[8]  = '{1'b0, 1'b1, 6'b000111, 6'b010110};
        tab[9]  = '{1'b0, 1'b1, 6'b000111, 6'b000010};
        tab[10] = '{1'b0, 1'b0, 6'b000000, 6'b000001};
        tab[11] = '{1'b0, 1'b0, 6'b000000, 6'b000001};
        for (int i = 0; i < 12; i++)
            step(tab[i].r, {2'b00, tab[i].lv}, tab[i].d, '0, '0, 1'b1, tab[i].exp);

        // LSB-first instance with the same word: expect 0,1,0,0,1,1.
        step(1'b0, 3'b010, '0, 6'b110010, '0, 1'b0, '0);
        idle_steps(9);

        // Back-to-back with load_valid held: gap-1 instance re-accepts 8 cycles
        // later, gap-0 instance 7 cycles later.
        for (int k = 0; k < 17; k++)
            step(1'b0, {(k <= 7), 1'b0, (k <= 8)},
                 (k == 0) ? 6'b111111 : 6'b000001, '0,
                 (k == 0) ? 6'b111111 : 6'b000001, 1'b0, '0);
        idle_steps(3);

        // Abandon a frame with an asynchronous reset while bit 3 is on the line.
        step(1'b0, 3'b001, 6'b101010, '0, '0, 1'b0, '0);
        step(1'b0, 3'b000, '0, '0, '0, 1'b0, '0);
        step(1'b0, 3'b000, '0, '0, '0, 1'b0, '0);
        step(1'b0, 3'b000, '0, '0, '0, 1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", sample(0), IDLE_REC);
        step(1'b1, 3'b000, '0, '0, '0, 1'b0, '0);
        step(1'b1, 3'b000, '0, '0, '0, 1'b0, '0);
        step(1'b0, 3'b001, 6'b011001, '0, '0, 1'b0, '0);
        idle_steps(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
